updown_counter_sequencer: RTL and testbench

Command-driven controller for the mod-N up/down counter. It accepts a command (direction, modulus, step count) over a valid/ready handshake, loads and steps an internal mod-N up/down counter core for exactly that many un-held cycles, and reports wrap events and completion. It sits between a control master (FSM or testbench) and the counter datapath, so the counter's mode and run length are set per command rather than by free-running.

---
 rtl/updown_counter_seq_pkg.sv | 16 +
 rtl/updown_mod_counter.sv | 49 ++++
 rtl/updown_counter_sequencer.sv | 96 +++++++++
 tb/tb_updown_counter_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_seq_pkg.sv
// Shared types and constants for the command-driven up/down counter sequencer.
package updown_counter_seq_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_STEP_W = 8;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/updown_mod_counter.sv
// Mod-N up/down counter core with load and a registered wrap pulse.
// mod = 0 encodes N = 2^WIDTH; the terminal value N-1 is simply mod-1 in
// WIDTH bits, which yields all-ones for the natural-wrap case.
module updown_mod_counter
  import updown_counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] out,
  output logic             wrap
);

  logic [WIDTH-1:0] w_max;
  logic             w_at_edge;
  logic [WIDTH-1:0] w_next;

  assign w_max = mod - WIDTH'(1);

  // Next value: wrap to the opposite end when sitting on the terminal value.
  always_comb begin
    w_at_edge = (mode == MODE_UP) ? (out == w_max) : (out == '0);
    if (w_at_edge) w_next = (mode == MODE_UP) ? '0 : w_max;
    else           w_next = (mode == MODE_UP) ? out + WIDTH'(1) : out - WIDTH'(1);
  end

  // Counter register; wrap is high only in the cycle showing a wrapped value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      out  <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      out  <= w_next;
      wrap <= w_at_edge;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/updown_counter_sequencer.sv
// Command sequencer: accepts (mode, N, K), loads the counter core and steps
// it K un-held cycles, reporting wrap and a one-cycle done at completion.
module updown_counter_sequencer
  import updown_counter_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [WIDTH-1:0]  cmd_mod,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              hold,
  input  logic              abort,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  seq_state_e        r_state;
  logic              r_mode;
  logic [WIDTH-1:0]  r_mod;
  logic [STEP_W-1:0] r_rem;
  logic              r_done;

  logic              w_accept;
  logic              w_step;
  logic [WIDTH-1:0]  w_load_val;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_step     = (r_state == ST_RUN) && !abort && !hold;
  // Start value comes straight from the command since the latch fills on the same edge.
  assign w_load_val = (cmd_mode == MODE_UP) ? '0 : cmd_mod - WIDTH'(1);

  updown_mod_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (w_step),
    .load     (w_accept),
    .load_val (w_load_val),
    .mode     (r_mode),
    .mod      (r_mod),
    .out      (out),
    .wrap     (wrap)
  );

  // Control FSM: command latch, remaining-step count and registered done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_UP;
      r_mod   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_mode <= cmd_mode;
            r_mod  <= cmd_mod;
            r_rem  <= cmd_steps;
            if (cmd_steps == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (!hold) begin
            r_rem <= r_rem - STEP_W'(1);
            if (r_rem == STEP_W'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Randomized and directed bench for updown_counter_sequencer against a
// behavioural model using modulo arithmetic on plain integers.
module tb_updown_counter_sequencer;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [WIDTH-1:0]  cmd_mod;
  logic [STEP_W-1:0] cmd_steps;
  logic              hold;
  logic              abort;
  logic [WIDTH-1:0]  out;
  logic              busy;
  logic              wrap;
  logic              done;

  updown_counter_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_mod   (cmd_mod),
    .cmd_steps (cmd_steps),
    .hold      (hold),
    .abort     (abort),
    .out       (out),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = counting, 2 = completion cycle.
  int m_phase, m_out, m_n, m_rem;
  bit m_up, m_wrap, m_done;

  int log_out[$];
  int done_at;

  function automatic void model_reset();
    m_phase = 0; m_out = 0; m_n = 16; m_rem = 0;
    m_up = 1; m_wrap = 0; m_done = 0;
  endfunction

  function automatic void model_edge();
    int nv;
    m_wrap = 0;
    m_done = 0;
    case (m_phase)
      0: if (cmd_valid) begin
        m_up   = cmd_mode;
        m_n    = (cmd_mod == 0) ? (1 << WIDTH) : int'(cmd_mod);
        m_rem  = int'(cmd_steps);
        m_out  = m_up ? 0 : m_n - 1;
        m_phase = (m_rem > 0) ? 1 : 2;
        m_done  = (m_rem == 0);
      end
      1: if (abort) m_phase = 0;
         else if (!hold) begin
           nv = m_up ? (m_out + 1) % m_n : (m_out + m_n - 1) % m_n;
           m_wrap = m_up ? (nv != m_out + 1) : (nv != m_out - 1);
           m_out = nv;
           m_rem--;
           if (m_rem == 0) begin m_phase = 2; m_done = 1; end
         end
      default: m_phase = 0;
    endcase
  endfunction

  // One clock: drive inputs, advance model, compare at the falling edge.
  task automatic cyc(input bit v, input bit md, input int nmod, input int k,
                     input bit h, input bit a);
    cmd_valid = v; cmd_mode = md; cmd_mod = WIDTH'(nmod); cmd_steps = STEP_W'(k);
    hold = h; abort = a;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("out", int'(out), m_out);
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("done", int'(done), int'(m_done));
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("cmd_ready", int'(cmd_ready), int'(m_phase == 0));
    if (done && done_at < 0) done_at = log_out.size();
    log_out.push_back(int'(out));
  endtask

  // Issue one command, then run until the model returns to idle.
  task automatic go(input bit md, input int nmod, input int k,
                    input int hold_at, input int hold_len, input int abort_at);
    int c;
    log_out.delete();
    done_at = -1;
    cyc(1, md, nmod, k, 0, 0);
    c = 1;
    while (m_phase != 0 && c < 600) begin
      cyc(0, md, nmod, k, (c >= hold_at && c < hold_at + hold_len),
          (c == abort_at) || (c == abort_at && hold_at == c));
      c++;
    end
    if (c >= 600) chk("timeout", 1, 0);
  endtask

  initial begin
    int exp_seq[8];
    reset = 1'b0; cmd_valid = 0; cmd_mode = 1; cmd_mod = '0; cmd_steps = '0;
    hold = 0; abort = 0;
    model_reset();
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(wrap), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Up N=5 K=7
    go(1, 5, 7, 1000, 0, 1000);
    exp_seq = '{0, 1, 2, 3, 4, 0, 1, 2};
    for (int i = 0; i < 8; i++) chk("up5_seq", log_out[i], exp_seq[i]);
    chk("up5_done_cyc", done_at, 7);

    // Down N=16 K=3, then down N=3 K=4
    go(0, 0, 3, 1000, 0, 1000);
    chk("dn16_final", log_out[3], 12);
    go(0, 3, 4, 1000, 0, 1000);
    chk("dn3_wrapval", log_out[3], 2);

    // Hold two cycles once out=1 shows
    go(1, 10, 4, 2, 2, 1000);
    chk("hold_done_cyc", done_at, 6);
    chk("hold_final", log_out[done_at], 4);

    // Abort together with hold when out=2 shows; next command right away
    go(1, 8, 6, 3, 1, 3);
    chk("abort_nodone", done_at, -1);
    chk("abort_out", log_out[log_out.size() - 1], 2);
    go(0, 7, 2, 1000, 0, 1000);

    // K=0 and N=1 corner cases
    go(1, 9, 0, 1000, 0, 1000);
    chk("k0_done_cyc", done_at, 0);
    go(1, 1, 3, 1000, 0, 1000);
    chk("n1_done_cyc", done_at, 3);

    // Reset in the middle of a run at out=3
    cyc(1, 1, 8, 10, 0, 0);
    repeat (3) cyc(0, 1, 8, 10, 0, 0);
    chk("pre_rst_out", int'(out), 3);
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_out", int'(out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    go(1, 4, 2, 1000, 0, 1000);
    chk("post_rst_done", done_at, 2);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int k;
      k = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), k,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
